fetch_stage: RTL and testbench

- PC generator and IF/ID pipeline register for the RV32I hart, directly upstream of and wrapped around instruct_mem.
- Drives Program_Count into the asynchronous-read instruction memory and captures the returned Instruction together with its PC into a registered IF/ID slot.
- The slot presents to decode with a valid/ready handshake.
- Handles stalls, branch/jump redirects with flush, misaligned-target faults, and counts accepted fetches.

---
 rtl/rv32_pkg.sv | 27 ++
 rtl/fetch_stage_if.sv | 46 ++++
 rtl/fetch_stage_if_id_reg.sv | 35 +++
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types and constants used by the fetch stage and the
// downstream decode stage.
package rv32_pkg;

    localparam int          XLEN        = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    // RV32I without the C extension only allows word-aligned fetch targets.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-side bundle: instruction memory port, redirect input from execute and
// the IF/ID handshake toward decode.
interface fetch_stage_if #(
    parameter int DWIDTH = 32
);
    logic [DWIDTH-1:0] Program_Count;
    logic [31:0]       Instruction;
    logic              Redirect_Valid;
    logic [DWIDTH-1:0] Redirect_Target;
    logic              ID_Ready;
    logic              ID_Valid;
    logic [31:0]       ID_Instruction;
    logic [DWIDTH-1:0] ID_PC;
    logic [DWIDTH-1:0] ID_PC_Plus4;
    logic              Fetch_Fault;
    logic [31:0]       Fetch_Count;

    modport master (
        output Program_Count,
        output ID_Valid,
        output ID_Instruction,
        output ID_PC,
        output ID_PC_Plus4,
        output Fetch_Fault,
        output Fetch_Count,
        input  Instruction,
        input  Redirect_Valid,
        input  Redirect_Target,
        input  ID_Ready
    );

    modport slave (
        input  Program_Count,
        input  ID_Valid,
        input  ID_Instruction,
        input  ID_PC,
        input  ID_PC_Plus4,
        input  Fetch_Fault,
        input  Fetch_Count,
        output Instruction,
        output Redirect_Valid,
        output Redirect_Target,
        output ID_Ready
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID slot register: reset to a NOP bubble, flush drops validity, load
// captures a new fetched instruction.
module if_id_reg
    import rv32_pkg::*;
(
    input  logic   clk,
    input  logic   srst,
    input  logic   load,
    input  logic   flush,
    input  if_id_t slot_d,
    output if_id_t slot_q
);

    if_id_t slot_next;

    // Flush wins over load so a redirect never lets a wrong-path word through.
    always_comb begin
        slot_next = slot_q;
        if (flush) begin
            slot_next.valid = 1'b0;
        end else if (load) begin
            slot_next       = slot_d;
            slot_next.valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            slot_q <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
        end else begin
            slot_q <= slot_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I PC generator and IF/ID pipeline slot wrapped around an
// asynchronous-read instruction memory.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter int                DWIDTH   = 32,
    parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
    input  logic          Clk_Core,
    input  logic          Rst_Core,
    fetch_stage_if.master bus
);

    fetch_state_t      state_q, state_d;
    logic [DWIDTH-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic [31:0]       count_q, count_d;

    logic [DWIDTH-1:0] pc_plus4;
    logic              load;
    logic              capture;
    logic              flush;
    logic              target_misaligned;
    if_id_t            slot_d, slot_q;

    assign pc_plus4          = pc_q + DWIDTH'(INSTR_BYTES);
    assign load              = !slot_q.valid || bus.ID_Ready;
    assign target_misaligned = is_misaligned(bus.Redirect_Target[1:0]);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        count_d = count_q;
        capture = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                if (bus.Redirect_Valid) begin
                    pc_d = bus.Redirect_Target;
                    if (target_misaligned) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bus.Redirect_Valid) begin
                    // The word at pc_q is wrong-path; fetch resumes from the
                    // target next cycle, costing one bubble.
                    pc_d  = bus.Redirect_Target;
                    flush = 1'b1;
                    if (target_misaligned) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end
                end else if (load) begin
                    capture = 1'b1;
                    pc_d    = pc_plus4;
                    count_d = count_q + 32'd1;
                end
            end
            S_FAULT: begin
                flush = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
                fault_d = 1'b1;
                flush   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign slot_d = '{
        instr:    bus.Instruction,
        pc:       XLEN'(pc_q),
        pc_plus4: XLEN'(pc_plus4),
        valid:    1'b1
    };

    if_id_reg u_if_id_reg (
        .clk    (Clk_Core),
        .srst   (Rst_Core),
        .load   (capture),
        .flush  (flush),
        .slot_d (slot_d),
        .slot_q (slot_q)
    );

    assign bus.Program_Count  = pc_q;
    assign bus.ID_Valid       = slot_q.valid;
    assign bus.ID_Instruction = slot_q.instr;
    assign bus.ID_PC          = DWIDTH'(slot_q.pc);
    assign bus.ID_PC_Plus4    = DWIDTH'(slot_q.pc_plus4);
    assign bus.Fetch_Fault    = fault_q;
    assign bus.Fetch_Count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage with a combinational instruction
// memory model (word k holds 32'h0010_0093 + k).
module tb_fetch_stage;
    import rv32_pkg::*;

    logic Clk_Core = 1'b0;
    logic Rst_Core = 1'b1;

    fetch_stage_if #(.DWIDTH(32)) bus ();

    fetch_stage #(.DWIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .Clk_Core (Clk_Core),
        .Rst_Core (Rst_Core),
        .bus      (bus.master)
    );

    always #5 Clk_Core = ~Clk_Core;

    assign bus.Instruction = 32'h0010_0093 + (bus.Program_Count >> 2);

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h0010_0093 + (addr >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic step();
        @(posedge Clk_Core);
        #1;
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rt;
        logic        e_valid;
        logic [31:0] e_idpc;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
        logic        e_fault;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    initial begin
        //           rdy   rv    target        valid idpc          pc            cnt    fault
        vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        32'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h4,        32'd1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        32'h8,        32'd2, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'hC,        32'd3, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'hC,        32'd3, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'hC,        32'd3, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'hC,        32'd3, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        32'h10,       32'd4, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       32'h14,       32'd5, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h40,       1'b0, 32'h0,        32'h40,       32'd5, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h40,       32'h44,       32'd6, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 32'hFFFF_FFFC,1'b0, 32'h0,        32'hFFFF_FFFC,32'd6, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC,32'h0,        32'd7, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h4,        32'd8, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 32'h42,       1'b0, 32'h0,        32'h42,       32'd8, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 32'h80,       1'b0, 32'h0,        32'h42,       32'd8, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h42,       32'd8, 1'b1};

        bus.ID_Ready        = 1'b0;
        bus.Redirect_Valid  = 1'b0;
        bus.Redirect_Target = 32'h0;

        // Reset state
        step();
        Rst_Core = 1'b0;
        chk("rst_valid", 32'(bus.ID_Valid), 32'd0);
        chk("rst_instr", bus.ID_Instruction, NOP_INSTR);
        chk("rst_idpc", bus.ID_PC, 32'h0);
        chk("rst_idpc4", bus.ID_PC_Plus4, 32'h0);
        chk("rst_fault", 32'(bus.Fetch_Fault), 32'd0);
        chk("rst_count", bus.Fetch_Count, 32'd0);
        chk("rst_pc", bus.Program_Count, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            bus.ID_Ready        = vecs[i].rdy;
            bus.Redirect_Valid  = vecs[i].rv;
            bus.Redirect_Target = vecs[i].rt;
            step();
            chk($sformatf("v%0d_valid", i), 32'(bus.ID_Valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_pc", i), bus.Program_Count, vecs[i].e_pc);
            chk($sformatf("v%0d_count", i), bus.Fetch_Count, vecs[i].e_cnt);
            chk($sformatf("v%0d_fault", i), 32'(bus.Fetch_Fault), 32'(vecs[i].e_fault));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_idpc", i), bus.ID_PC, vecs[i].e_idpc);
                chk($sformatf("v%0d_idpc4", i), bus.ID_PC_Plus4, vecs[i].e_idpc + 32'd4);
                chk($sformatf("v%0d_instr", i), bus.ID_Instruction, mem_word(vecs[i].e_idpc));
            end
        end

        // Reset clears a sticky fault and restarts at RESET_PC
        bus.Redirect_Valid = 1'b0;
        Rst_Core = 1'b1;
        step();
        Rst_Core = 1'b0;
        chk("clr_fault", 32'(bus.Fetch_Fault), 32'd0);
        chk("clr_pc", bus.Program_Count, 32'h0);
        chk("clr_valid", 32'(bus.ID_Valid), 32'd0);
        chk("clr_count", bus.Fetch_Count, 32'd0);

        // Misaligned redirect during the boot cycle
        bus.Redirect_Valid  = 1'b1;
        bus.Redirect_Target = 32'h6;
        step();
        bus.Redirect_Valid = 1'b0;
        chk("boot_mis_fault", 32'(bus.Fetch_Fault), 32'd1);
        chk("boot_mis_pc", bus.Program_Count, 32'h6);
        chk("boot_mis_valid", 32'(bus.ID_Valid), 32'd0);

        // Reset mid-stream with a simultaneous redirect
        Rst_Core = 1'b1;
        step();
        Rst_Core = 1'b0;
        bus.ID_Ready = 1'b1;
        step();
        step();
        step();
        chk("ms_pre_valid", 32'(bus.ID_Valid), 32'd1);
        chk("ms_pre_idpc", bus.ID_PC, 32'h4);
        Rst_Core            = 1'b1;
        bus.Redirect_Valid  = 1'b1;
        bus.Redirect_Target = 32'h40;
        step();
        Rst_Core           = 1'b0;
        bus.Redirect_Valid = 1'b0;
        chk("ms_valid", 32'(bus.ID_Valid), 32'd0);
        chk("ms_count", bus.Fetch_Count, 32'd0);
        chk("ms_pc", bus.Program_Count, 32'h0);
        chk("ms_instr", bus.ID_Instruction, NOP_INSTR);
        step();
        chk("ms_boot_valid", 32'(bus.ID_Valid), 32'd0);
        chk("ms_boot_pc", bus.Program_Count, 32'h0);
        step();
        chk("ms_run_valid", 32'(bus.ID_Valid), 32'd1);
        chk("ms_run_idpc", bus.ID_PC, 32'h0);
        chk("ms_run_count", bus.Fetch_Count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
